// File: rtl/sb_pkg.sv
// Shared definitions for the configurable switch box: side codes, FSM states, address/word decode.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package sb_pkg;

    // Side codes held in the low three bits of a config word; 5..7 behave like SIDE_NONE.
    localparam logic [2:0] SIDE_NONE   = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_COMMIT = 2'd2
    } sb_state_t;

    // A pin location: which side it sits on and its index along that side.
    typedef struct packed {
        logic [2:0] side;
        logic [7:0] idx;
    } pin_loc_t;

    function automatic logic side_is_routed(input logic [2:0] side);
        return (side >= SIDE_TOP) && (side <= SIDE_LEFT);
    endfunction

    // Number of pins on a side; zero for the non-routing codes.
    function automatic int side_size(input logic [2:0] side, input int n_tb, input int n_lr);
        case (side)
            SIDE_TOP, SIDE_BOTTOM: return n_tb;
            SIDE_RIGHT, SIDE_LEFT: return n_lr;
            default:               return 0;
        endcase
    endfunction

    // Address map: top, then bottom, then left, then right. Out-of-range gives SIDE_NONE.
    function automatic pin_loc_t addr_to_loc(input int addr, input int n_tb, input int n_lr);
        pin_loc_t loc;
        loc.side = SIDE_NONE;
        loc.idx  = 8'd0;
        if (addr < n_tb) begin
            loc.side = SIDE_TOP;
            loc.idx  = 8'(addr);
        end else if (addr < 2*n_tb) begin
            loc.side = SIDE_BOTTOM;
            loc.idx  = 8'(addr - n_tb);
        end else if (addr < 2*n_tb + n_lr) begin
            loc.side = SIDE_LEFT;
            loc.idx  = 8'(addr - 2*n_tb);
        end else if (addr < 2*n_tb + 2*n_lr) begin
            loc.side = SIDE_RIGHT;
            loc.idx  = 8'(addr - 2*n_tb - n_lr);
        end
        return loc;
    endfunction

    // Split a config word {idx, side} into its fields.
    function automatic pin_loc_t word_to_loc(input int word, input int idx_w);
        pin_loc_t loc;
        loc.side = word[2:0];
        loc.idx  = 8'((word >> 3) & ((1 << idx_w) - 1));
        return loc;
    endfunction

endpackage

// File: rtl/sb_pin_mux.sv
// Per-pin source selector: picks one pin from the side named in the active config word.
// Latency: purely combinational.
// Backpressure: none; output follows inputs continuously.
module sb_pin_mux
    import sb_pkg::*;
#(
    parameter  int N_TB  = 5,
    parameter  int N_LR  = 4,
    parameter  int IDX_W = 3,
    localparam int CFG_W = IDX_W + 3
) (
    input  logic [CFG_W-1:0] word_i,
    input  logic [N_TB-1:0]  top_i,
    input  logic [N_TB-1:0]  bottom_i,
    input  logic [N_LR-1:0]  left_i,
    input  logic [N_LR-1:0]  right_i,
    output logic             en_o,
    output logic             val_o
);

    // Sides are widened to the full index range so any idx value selects a defined bit.
    localparam int SRC_W = 1 << IDX_W;

    logic [SRC_W-1:0] top_ext;
    logic [SRC_W-1:0] bottom_ext;
    logic [SRC_W-1:0] left_ext;
    logic [SRC_W-1:0] right_ext;
    logic [2:0]       side;
    logic [IDX_W-1:0] idx;

    assign top_ext    = SRC_W'(top_i);
    assign bottom_ext = SRC_W'(bottom_i);
    assign left_ext   = SRC_W'(left_i);
    assign right_ext  = SRC_W'(right_i);
    assign side       = word_i[2:0];
    assign idx        = word_i[CFG_W-1:3];

    // Drive only for the four routing side codes; everything else leaves the pin floating.
    always_comb begin
        en_o  = 1'b0;
        val_o = 1'b0;
        case (side)
            SIDE_TOP:    begin en_o = 1'b1; val_o = top_ext[idx];    end
            SIDE_RIGHT:  begin en_o = 1'b1; val_o = right_ext[idx];  end
            SIDE_BOTTOM: begin en_o = 1'b1; val_o = bottom_ext[idx]; end
            SIDE_LEFT:   begin en_o = 1'b1; val_o = left_ext[idx];   end
            default:     ;
        endcase
    end

endmodule

// File: rtl/cfg_switch_box.sv
// Run-time configurable routing switch box: shadow config bank, atomic commit, sequential clear.
// Latency: write lands in shadow next edge; commit reaches pins 2 edges after request; clear busy NPIN cycles.
// Backpressure: cfg_ready low during CLEAR/COMMIT; commit/clear pulses and writes outside IDLE are dropped.
module cfg_switch_box
    import sb_pkg::*;
#(
    parameter  int N_TB   = 5,
    parameter  int N_LR   = 4,
    parameter  int IDX_W  = 3,
    localparam int NPIN   = 2*N_TB + 2*N_LR,
    localparam int ADDR_W = $clog2(NPIN),
    localparam int CFG_W  = IDX_W + 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CFG_W-1:0]  cfg_data,
    input  logic              cfg_commit,
    input  logic              cfg_clear,
    output logic              cfg_err,
    output logic              cfg_busy,
    inout  wire  [N_TB-1:0]   wtop,
    inout  wire  [N_TB-1:0]   wbottom,
    inout  wire  [N_LR-1:0]   wleft,
    inout  wire  [N_LR-1:0]   wright
);

    sb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              err_q, err_d;

    logic [CFG_W-1:0]  shadow_q [NPIN];
    logic [CFG_W-1:0]  active_q [NPIN];

    logic              wr_en;
    logic              clr_en;
    logic              commit_en;
    logic              wr_bad;
    pin_loc_t          dst_loc;
    pin_loc_t          src_loc;

    logic [NPIN-1:0]   drv_en;
    logic [NPIN-1:0]   drv_val;

    // Validate the offered write: address range, source index within its side, no self-loop.
    always_comb begin
        dst_loc = addr_to_loc(int'(cfg_addr), N_TB, N_LR);
        src_loc = word_to_loc(int'(cfg_data), IDX_W);
        wr_bad  = 1'b0;
        if (int'(cfg_addr) >= NPIN) begin
            wr_bad = 1'b1;
        end
        if (side_is_routed(src_loc.side) &&
            (int'(src_loc.idx) >= side_size(src_loc.side, N_TB, N_LR))) begin
            wr_bad = 1'b1;
        end
        if ((src_loc.side == dst_loc.side) && (src_loc.idx == dst_loc.idx)) begin
            wr_bad = 1'b1;
        end
    end

    // Next state and strobes; in IDLE clear beats commit beats write, losers are simply dropped.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        err_d     = 1'b0;
        wr_en     = 1'b0;
        clr_en    = 1'b0;
        commit_en = 1'b0;
        cfg_ready = 1'b0;
        cfg_busy  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_clear) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (cfg_commit) begin
                    state_d = ST_COMMIT;
                end else if (cfg_valid) begin
                    if (wr_bad) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                cfg_busy = 1'b1;
                clr_en   = 1'b1;
                if (clr_cnt_q == ADDR_W'(NPIN - 1)) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                cfg_busy  = 1'b1;
                commit_en = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Control registers: FSM state, clear pointer, error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            err_q     <= err_d;
        end
    end

    assign cfg_err = err_q;

    // Shadow bank: accepted writes and one-entry-per-cycle clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIN; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                shadow_q[cfg_addr] <= cfg_data;
            end
            if (clr_en) begin
                shadow_q[clr_cnt_q] <= '0;
            end
        end
    end

    // Active bank: whole-bank copy from shadow on the COMMIT exit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIN; i++) begin
                active_q[i] <= '0;
            end
        end else if (commit_en) begin
            for (int i = 0; i < NPIN; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    // One source mux per pin, indexed in the same order as the config address map.
    for (genvar p = 0; p < NPIN; p++) begin : g_mux
        sb_pin_mux #(
            .N_TB  (N_TB),
            .N_LR  (N_LR),
            .IDX_W (IDX_W)
        ) u_mux (
            .word_i   (active_q[p]),
            .top_i    (wtop),
            .bottom_i (wbottom),
            .left_i   (wleft),
            .right_i  (wright),
            .en_o     (drv_en[p]),
            .val_o    (drv_val[p])
        );
    end

    for (genvar i = 0; i < N_TB; i++) begin : g_tb_drv
        assign wtop[i]    = drv_en[i]        ? drv_val[i]        : 1'bz;
        assign wbottom[i] = drv_en[N_TB + i] ? drv_val[N_TB + i] : 1'bz;
    end

    for (genvar i = 0; i < N_LR; i++) begin : g_lr_drv
        assign wleft[i]  = drv_en[2*N_TB + i]        ? drv_val[2*N_TB + i]        : 1'bz;
        assign wright[i] = drv_en[2*N_TB + N_LR + i] ? drv_val[2*N_TB + N_LR + i] : 1'bz;
    end

endmodule

// File: tb/tb_cfg_switch_box.sv
// Directed bench for cfg_switch_box; pin nets are pulled up so a floating pin reads 1.
// Floating is told apart from routed by making the routed source 0 whenever floating is expected.
module tb_cfg_switch_box;

    localparam int N_TB   = 5;
    localparam int N_LR   = 4;
    localparam int ADDR_W = 5;
    localparam int CFG_W  = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_commit = 1'b0;
    logic              cfg_clear = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [CFG_W-1:0]  cfg_data = '0;
    wire               cfg_ready;
    wire               cfg_err;
    wire               cfg_busy;

    tri1 [N_TB-1:0] wtop;
    tri1 [N_TB-1:0] wbottom;
    tri1 [N_LR-1:0] wleft;
    tri1 [N_LR-1:0] wright;

    logic [N_TB-1:0] top_oe = '0;
    logic [N_TB-1:0] top_dv = '0;
    logic [N_LR-1:0] right_oe = '0;
    logic [N_LR-1:0] right_dv = '0;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar i = 0; i < N_TB; i++) begin : g_tb_top
        assign wtop[i] = top_oe[i] ? top_dv[i] : 1'bz;
    end
    for (genvar i = 0; i < N_LR; i++) begin : g_tb_right
        assign wright[i] = right_oe[i] ? right_dv[i] : 1'bz;
    end

    cfg_switch_box dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_clear  (cfg_clear),
        .cfg_err    (cfg_err),
        .cfg_busy   (cfg_busy),
        .wtop       (wtop),
        .wbottom    (wbottom),
        .wleft      (wleft),
        .wright     (wright)
    );

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %0h, nothing expected in queue", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [CFG_W-1:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Commit request plus the COMMIT cycle; on return the new active bank is visible.
    task automatic commit_pulse();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        tick();
    endtask

    initial begin
        int n;

        // Reset state.
        right_oe = 4'hf;
        right_dv = 4'b0100;
        #2;
        push(1);       check("rst_ready", 32'(cfg_ready));
        push(0);       check("rst_busy", 32'(cfg_busy));
        push(0);       check("rst_err", 32'(cfg_err));
        push(5'h1f);   check("rst_wtop_z", 32'(wtop));
        push(5'h1f);   check("rst_wbottom_z", 32'(wbottom));
        push(4'hf);    check("rst_wleft_z", 32'(wleft));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Route right[2] -> top[0], visible only after commit latency.
        right_dv = 4'b0000;
        cfg_write(5'd0, 6'h12);
        push(0);       check("wr_ok_err", 32'(cfg_err));
        push(1);       check("pre_commit_wtop0_z", 32'(wtop[0]));
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        push(1);       check("commit_busy", 32'(cfg_busy));
        push(0);       check("commit_ready", 32'(cfg_ready));
        push(1);       check("commit_1edge_wtop0_z", 32'(wtop[0]));
        tick();
        push(0);       check("commit_2edge_wtop0", 32'(wtop[0]));
        push(0);       check("commit_done_busy", 32'(cfg_busy));

        // Rejected writes: self-loop, index past side size, address past the map.
        cfg_write(5'd0, 6'h01);
        push(1);       check("selfloop_err", 32'(cfg_err));
        tick();
        push(0);       check("selfloop_err_one_cycle", 32'(cfg_err));
        cfg_write(5'd10, 6'h2C);
        push(1);       check("left5_err", 32'(cfg_err));
        tick();
        cfg_write(5'd18, 6'h09);
        push(1);       check("addr18_err", 32'(cfg_err));
        cfg_write(5'd3, 6'h38);
        push(0);       check("side0_idx7_ok", 32'(cfg_err));
        commit_pulse();
        push(0);       check("shadow0_kept_wtop0", 32'(wtop[0]));
        push(1);       check("side0_wtop3_z", 32'(wtop[3]));

        // top[1] -> bottom0, then clear: active unaffected, busy for the whole sweep.
        top_oe = 5'b00010;
        top_dv = 5'b00000;
        cfg_write(5'd5, 6'h09);
        commit_pulse();
        push(0);       check("bottom0_follows_top1", 32'(wbottom[0]));
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        push(0);       check("clear_ready", 32'(cfg_ready));
        n = 0;
        while (cfg_busy === 1'b1 && n < 40) begin
            n++;
            if (n == 9) begin
                push(0);
                check("mid_clear_bottom0", 32'(wbottom[0]));
            end
            tick();
        end
        push(18);      check("clear_busy_cycles", 32'(n));
        push(1);       check("post_clear_ready", 32'(cfg_ready));
        commit_pulse();
        push(1);       check("clear_commit_bottom0_z", 32'(wbottom[0]));
        push(1);       check("clear_commit_wtop0_z", 32'(wtop[0]));

        // Coincident clear/commit/write: only CLEAR runs; commit during CLEAR ignored.
        cfg_write(5'd5, 6'h09);
        commit_pulse();
        push(0);       check("resetup_bottom0", 32'(wbottom[0]));
        cfg_clear  = 1'b1;
        cfg_commit = 1'b1;
        cfg_valid  = 1'b1;
        cfg_addr   = 5'd0;
        cfg_data   = 6'h01;
        tick();
        cfg_clear  = 1'b0;
        cfg_commit = 1'b0;
        cfg_valid  = 1'b0;
        push(0);       check("combo_no_err", 32'(cfg_err));
        n = 0;
        while (cfg_busy === 1'b1 && n < 40) begin
            n++;
            cfg_commit = (n == 10);
            if (n == 14) begin
                push(0);
                check("commit_in_clear_ignored", 32'(wbottom[0]));
            end
            tick();
        end
        cfg_commit = 1'b0;
        push(18);      check("combo_clear_cycles", 32'(n));
        push(0);       check("combo_active_kept", 32'(wbottom[0]));
        commit_pulse();
        push(1);       check("combo_commit_bottom0_z", 32'(wbottom[0]));

        // Reset in the middle of CLEAR.
        cfg_write(5'd5, 6'h09);
        commit_pulse();
        push(0);       check("prerst_bottom0", 32'(wbottom[0]));
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        push(1);       check("midclr_rst_bottom0_z", 32'(wbottom[0]));
        push(1);       check("midclr_rst_ready", 32'(cfg_ready));
        push(0);       check("midclr_rst_busy", 32'(cfg_busy));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cfg_write(5'd5, 6'h09);
        commit_pulse();
        push(0);       check("postrst_bottom0", 32'(wbottom[0]));

        // Chain: top[0] -> left0 -> right0.
        right_oe = 4'b1110;
        top_oe   = 5'b00011;
        top_dv   = 5'b00001;
        cfg_write(5'd10, 6'h01);
        cfg_write(5'd14, 6'h04);
        commit_pulse();
        push(1);       check("chain_right0_hi", 32'(wright[0]));
        top_dv = 5'b00000;
        #1;
        push(0);       check("chain_right0_lo", 32'(wright[0]));
        push(0);       check("chain_left0_lo", 32'(wleft[0]));

        if (exp_q.size() != 0) begin
            miscompares++;
            $error("FAIL leftover_expectations: observed %0d queued, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
